// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, write-back mux, load-data hold across stalls.
// Optional retire counter built only when WB_RETIRE_CNT_EN is defined.
module wb_stage #(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int RETIRE_W = 64
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                VALID_EM,
  input  logic [RA_W-1:0]     RD_EM,
  input  logic                RegWrite_EM,
  input  logic [1:0]          WBSel_EM,
  input  logic [1:0]          MemRead_EM,
  input  logic [XLEN-1:0]     ALU_VAL_EM,
  input  logic [XLEN-1:0]     PC_EM,
  input  logic [XLEN-1:0]     MEM_DATA_M,
  input  logic                STALL,
  input  logic                FLUSH,
  output logic                VALID_W,
  output logic                RF_WE_W,
  output logic [RA_W-1:0]     RF_WA_W,
  output logic [XLEN-1:0]     RF_WD_W,
  output logic [XLEN-1:0]     FWD_VAL_W,
  output logic                LOAD_PEND_W,
  output logic [RETIRE_W-1:0] RETIRE_CNT
);
  typedef enum logic {LIVE, HELD} hold_state_t;
  hold_state_t state, state_nx;
  logic            reg_write_w;
  logic [1:0]      wb_sel_w, mem_read_w;
  logic [XLEN-1:0] alu_w, pc_w, hold_d, mem_val, pc4;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      VALID_W     <= 1'b0;
      RF_WA_W     <= '0;
      reg_write_w <= 1'b0;
      wb_sel_w    <= '0;
      mem_read_w  <= '0;
      alu_w       <= '0;
      pc_w        <= '0;
    end else if (!STALL) begin
      VALID_W     <= VALID_EM & ~FLUSH;
      RF_WA_W     <= FLUSH ? '0 : RD_EM;
      reg_write_w <= RegWrite_EM & ~FLUSH;
      wb_sel_w    <= FLUSH ? '0 : WBSel_EM;
      mem_read_w  <= FLUSH ? '0 : MemRead_EM;
      alu_w       <= FLUSH ? '0 : ALU_VAL_EM;
      pc_w        <= FLUSH ? '0 : PC_EM;
    end
  // Load data is only live for one cycle, so capture it when a stall begins.
  always_comb state_nx = !STALL ? LIVE : (state == LIVE && LOAD_PEND_W) ? HELD : state;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state  <= LIVE;
      hold_d <= '0;
    end else begin
      state <= state_nx;
      if (state == LIVE && state_nx == HELD) hold_d <= MEM_DATA_M;
    end
  assign mem_val     = (state == HELD) ? hold_d : MEM_DATA_M;
  assign pc4         = pc_w + XLEN'(4);
  assign RF_WD_W     = (wb_sel_w == 2'b01) ? mem_val : (wb_sel_w == 2'b10) ? pc4 : alu_w;
  assign FWD_VAL_W   = RF_WD_W;
  assign RF_WE_W     = VALID_W & reg_write_w & (RF_WA_W != '0);
  assign LOAD_PEND_W = VALID_W & (mem_read_w != 2'b00);
`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST) RETIRE_CNT <= '0;
    else if (VALID_W && !STALL) RETIRE_CNT <= RETIRE_CNT + RETIRE_W'(1);
`else
  assign RETIRE_CNT = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed checks of the write-back stage.
module tb_wb_stage;
  logic        CLK, RST, VALID_EM, RegWrite_EM, STALL, FLUSH;
  logic [4:0]  RD_EM;
  logic [1:0]  WBSel_EM, MemRead_EM;
  logic [31:0] ALU_VAL_EM, PC_EM, MEM_DATA_M;
  logic        VALID_W, RF_WE_W, LOAD_PEND_W;
  logic [4:0]  RF_WA_W;
  logic [31:0] RF_WD_W, FWD_VAL_W;
  logic [63:0] RETIRE_CNT;
  int passed = 0, total = 0;

  wb_stage dut (
    .CLK(CLK), .RST(RST), .VALID_EM(VALID_EM), .RD_EM(RD_EM), .RegWrite_EM(RegWrite_EM),
    .WBSel_EM(WBSel_EM), .MemRead_EM(MemRead_EM), .ALU_VAL_EM(ALU_VAL_EM), .PC_EM(PC_EM),
    .MEM_DATA_M(MEM_DATA_M), .STALL(STALL), .FLUSH(FLUSH), .VALID_W(VALID_W),
    .RF_WE_W(RF_WE_W), .RF_WA_W(RF_WA_W), .RF_WD_W(RF_WD_W), .FWD_VAL_W(FWD_VAL_W),
    .LOAD_PEND_W(LOAD_PEND_W), .RETIRE_CNT(RETIRE_CNT)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [63:0] rc(input int n);
`ifdef WB_RETIRE_CNT_EN
    return 64'(n);
`else
    return 64'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic em(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                    input logic [1:0] mr, input logic [31:0] alu, input logic [31:0] pc);
    VALID_EM = v; RD_EM = rd; RegWrite_EM = rw; WBSel_EM = sel;
    MemRead_EM = mr; ALU_VAL_EM = alu; PC_EM = pc;
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1; STALL = 0; FLUSH = 0; MEM_DATA_M = 0;
    em(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_valid", VALID_W, 0);
    chk("rst_we", RF_WE_W, 0);
    chk("rst_wd", RF_WD_W, 0);
    chk("rst_lp", LOAD_PEND_W, 0);
    chk("rst_cnt", RETIRE_CNT, 0);
    RST = 0;
    // ALU write
    em(1, 5, 1, 2'b00, 2'b00, 32'h12345678, 32'h100);
    step;
    chk("alu_we", RF_WE_W, 1);
    chk("alu_wa", RF_WA_W, 5);
    chk("alu_wd", RF_WD_W, 32'h12345678);
    chk("alu_fwd", FWD_VAL_W, 32'h12345678);
    chk("alu_lp", LOAD_PEND_W, 0);
    // load, then stall three cycles while dmem output changes
    em(1, 3, 1, 2'b01, 2'b10, 32'h0000AAAA, 32'h104);
    MEM_DATA_M = 32'hDEADBEEF;
    step;
    chk("ld_lp", LOAD_PEND_W, 1);
    chk("ld_wa", RF_WA_W, 3);
    chk("ld_wd", RF_WD_W, 32'hDEADBEEF);
    chk("ld_cnt", RETIRE_CNT, rc(1));
    STALL = 1;
    em(1, 9, 1, 2'b00, 2'b00, 32'h55, 32'h108);
    for (int i = 0; i < 3; i++) begin
      step;
      MEM_DATA_M = 32'h0;
      #1;
      chk("hold_wd", RF_WD_W, 32'hDEADBEEF);
      chk("hold_wa", RF_WA_W, 3);
      chk("hold_cnt", RETIRE_CNT, rc(1));
    end
    STALL = 0;
    step;
    chk("adv_wa", RF_WA_W, 9);
    chk("adv_wd", RF_WD_W, 32'h55);
    chk("adv_cnt", RETIRE_CNT, rc(2));
    // JAL link with PC wrap
    em(1, 1, 1, 2'b10, 2'b00, 32'h77, 32'hFFFFFFFC);
    step;
    chk("jal_we", RF_WE_W, 1);
    chk("jal_wd", RF_WD_W, 0);
    em(1, 0, 1, 2'b10, 2'b00, 32'h77, 32'hFFFFFFFC);
    step;
    chk("x0_valid", VALID_W, 1);
    chk("x0_we", RF_WE_W, 0);
    chk("x0_fwd", FWD_VAL_W, 0);
    chk("x0_cnt", RETIRE_CNT, rc(4));
    // reserved select behaves as ALU
    em(1, 2, 1, 2'b11, 2'b00, 32'h31415926, 32'h200);
    step;
    chk("sel11_wd", RF_WD_W, 32'h31415926);
    // flush vs stall
    FLUSH = 1;
    em(1, 7, 1, 2'b00, 2'b00, 32'h99, 32'h10C);
    step;
    chk("fl_valid", VALID_W, 0);
    chk("fl_we", RF_WE_W, 0);
    chk("fl_cnt", RETIRE_CNT, rc(6));
    FLUSH = 0;
    step;
    chk("post_fl_wa", RF_WA_W, 7);
    chk("post_fl_wd", RF_WD_W, 32'h99);
    chk("post_fl_cnt", RETIRE_CNT, rc(6));
    FLUSH = 1; STALL = 1;
    em(1, 8, 1, 2'b00, 2'b00, 32'h11, 32'h110);
    step;
    chk("fs_valid", VALID_W, 1);
    chk("fs_wa", RF_WA_W, 7);
    chk("fs_wd", RF_WD_W, 32'h99);
    chk("fs_cnt", RETIRE_CNT, rc(6));
    // reset while a load is held
    FLUSH = 0; STALL = 0;
    em(1, 4, 1, 2'b01, 2'b01, 32'h0, 32'h114);
    MEM_DATA_M = 32'hCAFEF00D;
    step;
    chk("ld2_lp", LOAD_PEND_W, 1);
    chk("ld2_cnt", RETIRE_CNT, rc(7));
    STALL = 1;
    step;
    MEM_DATA_M = 32'h0;
    #1;
    chk("ld2_hold", RF_WD_W, 32'hCAFEF00D);
    #1;
    RST = 1;
    #1;
    chk("arst_valid", VALID_W, 0);
    chk("arst_we", RF_WE_W, 0);
    chk("arst_lp", LOAD_PEND_W, 0);
    chk("arst_cnt", RETIRE_CNT, 0);
    RST = 0; STALL = 0;
    em(1, 6, 1, 2'b00, 2'b00, 32'h1234, 32'h118);
    step;
    chk("post_rst_we", RF_WE_W, 1);
    chk("post_rst_wa", RF_WA_W, 6);
    chk("post_rst_wd", RF_WD_W, 32'h1234);
    // after reset the load path is live again
    em(1, 10, 1, 2'b01, 2'b01, 32'h0, 32'h11C);
    MEM_DATA_M = 32'h0BADCAFE;
    step;
    chk("post_rst_ld", RF_WD_W, 32'h0BADCAFE);
    chk("post_rst_cnt", RETIRE_CNT, rc(1));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage directly downstream of mem_stage. Holds the MEM/WB pipeline register and selects the register-file write data from ALU result, load data (MEM_DATA_M) or PC+4.
- Drives the register-file write port and the WB forwarding value.
- Handles stall and flush, and keeps load data stable while W is stalled.
- Load data from mem_stage uses synchronous dmem. MEM_DATA_M is valid in the cycle after the load is presented on the EM register, which is the cycle it occupies W.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.
- RETIRE_W, 64, retire counter width (used only with the optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- VALID_EM  in  1  EM register holds a real instruction.
- RD_EM  in  RA_W  destination register.
- RegWrite_EM  in  1  instruction writes rd.
- WBSel_EM  in  2  00 ALU, 01 MEM, 10 PC+4, 11 reserved (treated as ALU).
- MemRead_EM  in  2  nonzero marks a load.
- ALU_VAL_EM  in  XLEN  EX result.
- PC_EM  in  XLEN  instruction PC.
- MEM_DATA_M  in  XLEN  aligned, extended load data from mem_stage; valid while the load is in W.
- STALL  in  1  hold the MW register.
- FLUSH  in  1  convert the instruction entering W into a bubble.
- VALID_W  out  1  W holds a real instruction.
- RF_WE_W  out  1  register-file write enable.
- RF_WA_W  out  RA_W  write address.
- RF_WD_W  out  XLEN  write data.
- FWD_VAL_W  out  XLEN  forwarding value, equal to RF_WD_W.
- LOAD_PEND_W  out  1  W holds a valid load (for the hazard unit).
- RETIRE_CNT  out  RETIRE_W  retired-instruction count.

Behaviour:
- Reset (async, RST=1): all MW register fields 0, VALID_W=0, hold register 0, HOLD_V=0, RETIRE_CNT=0. All outputs read 0 while RST is high.
- MW register update on the CLK edge:
  - STALL=1: register holds. STALL has priority over FLUSH, so FLUSH is ignored in that cycle.
  - STALL=0, FLUSH=1: VALID_W<=0 and the other fields are don't-care but cleared to 0.
  - Otherwise: capture all EM fields; VALID_W<=VALID_EM.
- Latency: an instruction in EM in cycle n is in W in cycle n+1. RF write occurs at the end of cycle n+1.
- PC+4: computed from the registered PC with a modulo-2^XLEN add (0xFFFFFFFC -> 0x00000000).
- Load hold (2-state FSM, LIVE/HELD):
  - LIVE: the MEM path uses MEM_DATA_M directly.
  - LIVE -> HELD: on an edge where STALL=1 and LOAD_PEND_W=1, capture MEM_DATA_M into the hold register and set HOLD_V=1.
  - HELD: the MEM path uses the hold register.
  - HELD -> LIVE: on an edge where STALL=0 (W advances), or on RST.
- Write data mux:
  - WBSel 00 or 11: ALU value.
  - WBSel 01: load data (live or held per the FSM).
  - WBSel 10: PC+4.
- RF_WE_W = VALID_W & RegWrite & (RF_WA_W != 0). Writes to x0 are never issued, but FWD_VAL_W is still driven.
- Repeated writes while stalled are permitted; they are idempotent because the data is held.
- LOAD_PEND_W = VALID_W & (MemRead != 0).
- Retirement: an instruction retires on the edge where VALID_W=1 and STALL=0. A stalled instruction retires once.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined: RETIRE_CNT increments by 1 on each retirement edge and wraps modulo 2^RETIRE_W.
- Undefined: the counter logic is not built and RETIRE_CNT is tied to 0.
- The port list is identical in both builds.

Test Plan:
- ALU write: RD=5, WBSel=00, ALU=0x12345678 in EM -> next cycle RF_WE_W=1, RF_WA_W=5, RF_WD_W=0x12345678.
- Load with stall: LW to RD=3, MEM_DATA_M=0xDEADBEEF in W, STALL high for 3 cycles while MEM_DATA_M changes to 0x0 -> RF_WD_W stays 0xDEADBEEF; with the feature, RETIRE_CNT increments by exactly 1 after STALL drops.
- JAL link: WBSel=10, PC=0xFFFFFFFC -> RF_WD_W=0x00000000. Same with RD=0 -> RF_WE_W=0 while FWD_VAL_W=0x00000000.
- Flush vs stall: FLUSH=1, STALL=0 -> VALID_W=0 next cycle, RF_WE_W=0. FLUSH=1, STALL=1 -> W contents unchanged.
- Reset mid-operation: assert RST asynchronously while a load is in HELD -> VALID_W, RF_WE_W, LOAD_PEND_W and RETIRE_CNT go to 0 immediately; the first instruction after release writes normally.
